alu_issue: RTL and testbench
============================

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state changes on its rising edge.
REQ-002 SHALL have port: rst  input  1  reset, asynchronous and active-high.
REQ-003 SHALL have port: ins_valid  input  1  instruction word offered.
REQ-004 SHALL have port: ins_ready  output  1  block accepts ins this cycle.
REQ-005 SHALL have port: ins  input  16  XM-23 register/constant arithmetic instruction word.
REQ-006 SHALL have ports: rf_raddr_a, rf_raddr_b  output  3  dst and src register addresses; rf_rdata_a, rf_rdata_b  input  16  data, valid one cycle after address.
REQ-007 SHALL have ports: rf_we  output  1; rf_waddr  output  3; rf_wdata  output  16  register write-back.
REQ-008 SHALL have ports: psw_i  input  16  current PSW; psw_we  output  1; psw_wdata  output  16.
REQ-009 SHALL have ALU-side ports: alu_op1, alu_op2  output  16; alu_instr  output  6; alu_opt  output  1; alu_e  output  1; alu_psw_i  output  16; alu_result, alu_psw_o  input  16.
REQ-010 SHALL have ports: done  output  1  one-cycle completion pulse; illegal  output  1  one-cycle reject pulse.

Function
REQ-011 SHALL accept ins on a rising edge with ins_valid=1 and ins_ready=1; ins_ready SHALL be 1 only in IDLE.
REQ-012 SHALL decode: ins[15:12]=0100 group; k=ins[11:8]; RC=ins[7]; WB=ins[6]; SC=ins[5:3]; D=ins[2:0].
REQ-013 SHALL treat k=0x0..0xB (ADD,ADDC,SUB,SUBC,DADD,CMP,XOR,AND,OR,BIT,BIC,BIS) as legal; alu_instr = {1'b0, k, WB}.
REQ-014 SHALL drive alu_op1 = dst register data; alu_op2 = src register data when RC=0, else constant table SC: 0,1,2,4,8,16,32,0xFFFF.
REQ-015 SHALL drive alu_opt=1 and alu_psw_i=psw_i latched in READ.
REQ-016 SHALL run FSM IDLE -> READ -> EXEC -> CAPT -> WB -> IDLE, one cycle per state.
REQ-017 READ: rf_raddr_a=D, rf_raddr_b=SC, held from the accept edge onward; operands latched at end of READ.
REQ-018 EXEC: alu_e=1 for exactly one cycle; op1/op2/instr stable from READ through CAPT.
REQ-019 CAPT: alu_e=0; alu_result and alu_psw_o latched at end of cycle.
REQ-020 WB: psw_we=1, psw_wdata=latched alu_psw_o, done=1; rf_we=1, rf_waddr=D, rf_wdata=latched result, except CMP (k=5) and BIT (k=9), where rf_we=0.
REQ-021 Latency: accept at edge T; alu_e high in cycle T+2; WB outputs in cycle T+4; ins_ready=1 again in cycle T+5.
REQ-022 Non-0100 group or undecoded k SHALL pulse illegal for one cycle after accept, skip ALU, issue no rf_we/psw_we/done, and return to IDLE (ins_ready in cycle T+2).
REQ-023 ins_valid during non-IDLE states SHALL be ignored, neither accepted nor stored.
REQ-024 rf_we, psw_we, alu_e, done, illegal SHALL be mutually exclusive in time except rf_we/psw_we/done together in WB.

Reset
REQ-025 rst=1 SHALL force IDLE immediately and zero all outputs, ins_ready included, while asserted.
REQ-026 rst mid-operation SHALL abort with no rf_we/psw_we/done; ins_ready=1 in the first cycle after deassert.

Configuration
REQ-027 Macro ALU_ISSUE_SHIFT_EN defined: k=0xD with SC=000 -> SRA (alu_instr={1'b0,4'hC,WB}), SC=001 -> RRC (alu_instr={1'b0,4'hD,WB}); single operand, dst only, rf_we=1.
REQ-028 Macro ALU_ISSUE_SHIFT_EN undefined: k=0xD SHALL be illegal per REQ-022.

Verification
REQ-029 R1=0x0005, R2=0x0003, ins=0x4011 (ADD R2,R1) -> alu_e one cycle at T+2; at T+4 rf_we=1, rf_waddr=1, rf_wdata=0x0008, psw_we=1, psw_wdata[1]=0, done=1.
REQ-030 R0=0x0001, ins=0x45C8 (CMP.B #1,R0) -> at T+4 rf_we=0, psw_we=1, psw_wdata[1]=1 (Z).
REQ-031 ins=0x4E00 -> illegal=1 at T+1; no alu_e/rf_we/psw_we; ins_ready=1 at T+2.
REQ-032 ins_valid held high with two ADDs -> second accepted at T+5; no accept during T+1..T+4.
REQ-033 rst pulsed during EXEC -> all outputs 0, no rf_we/psw_we ever issued for that instruction; ins_ready=1 the cycle after deassert.
REQ-034 With ALU_ISSUE_SHIFT_EN, R3=0x8002, ins=0x4D03 (SRA R3) -> rf_wdata=0xC001; without the macro -> illegal pulse, no write.

Source files
------------

// File: rtl/alu_issue.sv
// alu_issue: XM-23 register/constant arithmetic issue sequencer (READ/EXEC/CAPT/WB).
// Define ALU_ISSUE_SHIFT_EN to also issue SRA/RRC (k=0xD, SC=0/1).
module alu_issue (
   input  logic        clk,
   input  logic        rst,
   input  logic        ins_valid,
   output logic        ins_ready,
   input  logic [15:0] ins,
   output logic [2:0]  rf_raddr_a,
   output logic [2:0]  rf_raddr_b,
   input  logic [15:0] rf_rdata_a,
   input  logic [15:0] rf_rdata_b,
   output logic        rf_we,
   output logic [2:0]  rf_waddr,
   output logic [15:0] rf_wdata,
   input  logic [15:0] psw_i,
   output logic        psw_we,
   output logic [15:0] psw_wdata,
   output logic [15:0] alu_op1,
   output logic [15:0] alu_op2,
   output logic [5:0]  alu_instr,
   output logic        alu_opt,
   output logic        alu_e,
   output logic [15:0] alu_psw_i,
   input  logic [15:0] alu_result,
   input  logic [15:0] alu_psw_o,
   output logic        done,
   output logic        illegal
);

   typedef enum logic [2:0] {
      S_IDLE, S_READ, S_EXEC, S_CAPT, S_WB, S_ILL
   } state_t;

   state_t      state_q, state_d;
   logic [2:0]  ra_q, ra_d;
   logic [2:0]  rb_q, rb_d;
   logic        rc_q, rc_d;
   logic        wr_q, wr_d;
   logic        single_q, single_d;
   logic        opt_q, opt_d;
   logic [5:0]  instr_q, instr_d;
   logic [15:0] op1_q, op1_d;
   logic [15:0] op2_q, op2_d;
   logic [15:0] apsw_q, apsw_d;
   logic [15:0] res_q, res_d;
   logic [15:0] pswo_q, pswo_d;
   logic        alu_e_q, alu_e_d;
   logic        rf_we_q, rf_we_d;
   logic        psw_we_q, psw_we_d;
   logic        done_q, done_d;
   logic        ill_q, ill_d;

   logic [3:0]  k;
   logic [2:0]  sc;
   logic        wb;
   logic        dec_legal;
   logic        dec_wr;
   logic        dec_single;
   logic [5:0]  dec_instr;
   logic [15:0] cval;
   logic        in_read;
   logic [15:0] op1_w, op2_w, apsw_w;

   assign k  = ins[11:8];
   assign sc = ins[5:3];
   assign wb = ins[6];

   always_comb begin
      dec_legal  = 1'b0;
      dec_wr     = 1'b1;
      dec_single = 1'b0;
      dec_instr  = {1'b0, k, wb};
      if (ins[15:12] == 4'b0100) begin
         unique case (1'b1)
            (k <= 4'hB): begin
               dec_legal = 1'b1;
               dec_wr    = (k != 4'h5) && (k != 4'h9);
            end
`ifdef ALU_ISSUE_SHIFT_EN
            ((k == 4'hD) && (sc == 3'd0)): begin
               dec_legal  = 1'b1;
               dec_single = 1'b1;
               dec_instr  = {1'b0, 4'hC, wb};
            end
            ((k == 4'hD) && (sc == 3'd1)): begin
               dec_legal  = 1'b1;
               dec_single = 1'b1;
               dec_instr  = {1'b0, 4'hD, wb};
            end
`endif
            default: ;
         endcase
      end
   end

   always_comb begin
      unique case (rb_q)
         3'd0: cval = 16'h0000;
         3'd1: cval = 16'h0001;
         3'd2: cval = 16'h0002;
         3'd3: cval = 16'h0004;
         3'd4: cval = 16'h0008;
         3'd5: cval = 16'h0010;
         3'd6: cval = 16'h0020;
         3'd7: cval = 16'hFFFF;
      endcase
   end

   // Operands flow straight from the RF during READ so the ALU sees
   // the same values from READ onward; the latched copy covers EXEC/CAPT.
   assign in_read = (state_q == S_READ);
   assign op1_w   = in_read ? rf_rdata_a : op1_q;
   assign op2_w   = !in_read ? op2_q :
                    single_q ? 16'h0000 :
                    rc_q     ? cval : rf_rdata_b;
   assign apsw_w  = in_read ? psw_i : apsw_q;

   assign ins_ready = (state_q == S_IDLE) && !rst;

   always_comb begin
      state_d  = state_q;
      ra_d     = ra_q;
      rb_d     = rb_q;
      rc_d     = rc_q;
      wr_d     = wr_q;
      single_d = single_q;
      opt_d    = opt_q;
      instr_d  = instr_q;
      op1_d    = op1_q;
      op2_d    = op2_q;
      apsw_d   = apsw_q;
      res_d    = res_q;
      pswo_d   = pswo_q;
      alu_e_d  = 1'b0;
      rf_we_d  = 1'b0;
      psw_we_d = 1'b0;
      done_d   = 1'b0;
      ill_d    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (ins_valid && ins_ready) begin
               if (dec_legal) begin
                  state_d  = S_READ;
                  ra_d     = ins[2:0];
                  rb_d     = sc;
                  rc_d     = ins[7];
                  wr_d     = dec_wr;
                  single_d = dec_single;
                  instr_d  = dec_instr;
                  opt_d    = 1'b1;
               end else begin
                  state_d = S_ILL;
                  ill_d   = 1'b1;
               end
            end
         end
         S_READ: begin
            op1_d   = op1_w;
            op2_d   = op2_w;
            apsw_d  = apsw_w;
            alu_e_d = 1'b1;
            state_d = S_EXEC;
         end
         S_EXEC: state_d = S_CAPT;
         S_CAPT: begin
            res_d    = alu_result;
            pswo_d   = alu_psw_o;
            rf_we_d  = wr_q;
            psw_we_d = 1'b1;
            done_d   = 1'b1;
            state_d  = S_WB;
         end
         S_WB:  state_d = S_IDLE;
         S_ILL: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         ra_q     <= '0;
         rb_q     <= '0;
         rc_q     <= 1'b0;
         wr_q     <= 1'b0;
         single_q <= 1'b0;
         opt_q    <= 1'b0;
         instr_q  <= '0;
         op1_q    <= '0;
         op2_q    <= '0;
         apsw_q   <= '0;
         res_q    <= '0;
         pswo_q   <= '0;
         alu_e_q  <= 1'b0;
         rf_we_q  <= 1'b0;
         psw_we_q <= 1'b0;
         done_q   <= 1'b0;
         ill_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         ra_q     <= ra_d;
         rb_q     <= rb_d;
         rc_q     <= rc_d;
         wr_q     <= wr_d;
         single_q <= single_d;
         opt_q    <= opt_d;
         instr_q  <= instr_d;
         op1_q    <= op1_d;
         op2_q    <= op2_d;
         apsw_q   <= apsw_d;
         res_q    <= res_d;
         pswo_q   <= pswo_d;
         alu_e_q  <= alu_e_d;
         rf_we_q  <= rf_we_d;
         psw_we_q <= psw_we_d;
         done_q   <= done_d;
         ill_q    <= ill_d;
      end
   end

   assign rf_raddr_a = ra_q;
   assign rf_raddr_b = rb_q;
   assign rf_we      = rf_we_q;
   assign rf_waddr   = ra_q;
   assign rf_wdata   = res_q;
   assign psw_we     = psw_we_q;
   assign psw_wdata  = pswo_q;
   assign alu_op1    = op1_w;
   assign alu_op2    = op2_w;
   assign alu_instr  = instr_q;
   assign alu_opt    = opt_q;
   assign alu_e      = alu_e_q;
   assign alu_psw_i  = apsw_w;
   assign done       = done_q;
   assign illegal    = ill_q;

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: bench with RF/PSW/ALU models around alu_issue and an
// instruction-level reference for timing, routing and write-back.
module tb_alu_issue;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ins_valid = 1'b0;
   logic [15:0] ins = 16'h0;
   logic        ins_ready;
   logic [2:0]  rf_raddr_a, rf_raddr_b, rf_waddr;
   logic [15:0] rf_rdata_a, rf_rdata_b, rf_wdata;
   logic        rf_we, psw_we, alu_opt, alu_e, done, illegal;
   logic [15:0] psw_i, psw_wdata, alu_op1, alu_op2, alu_psw_i;
   logic [15:0] alu_result, alu_psw_o;
   logic [5:0]  alu_instr;

   logic [15:0] regs [8];
   logic [15:0] ctab [8];
   logic [15:0] psw_m;
   logic        tb_we = 1'b0;
   logic [2:0]  tb_wa = 3'd0;
   logic [15:0] tb_wd = 16'h0;
   logic        tb_pwe = 1'b0;
   logic [15:0] tb_pd = 16'h0;
   int          tests = 0;
   int          fails = 0;
   int          wcount = 0;
   logic [101:0] outs_v;

   typedef struct packed {
      logic [7:0]  ae, il, rdy, rwe, pwe, dn;
      logic [5:0]  instr;
      logic [2:0]  ra, rb, wa;
      logic [15:0] wd, pd;
      logic [7:0]  excl;
   } obs_t;

   alu_issue dut (
      .clk(clk), .rst(rst),
      .ins_valid(ins_valid), .ins_ready(ins_ready), .ins(ins),
      .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
      .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .psw_i(psw_i), .psw_we(psw_we), .psw_wdata(psw_wdata),
      .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_instr(alu_instr),
      .alu_opt(alu_opt), .alu_e(alu_e), .alu_psw_i(alu_psw_i),
      .alu_result(alu_result), .alu_psw_o(alu_psw_o),
      .done(done), .illegal(illegal)
   );

   always #5 clk = ~clk;

   // XM-23 style ALU: returns {psw_out, result}; PSW bits N=2, Z=1, C=0.
   function automatic logic [31:0] alu_f(input logic [5:0] ai,
                                         input logic [15:0] a,
                                         input logic [15:0] b,
                                         input logic [15:0] p);
      logic [15:0] m, aa, bb, top, res;
      logic [16:0] r;
      logic bm, cy, n, z;
      bm  = ai[0];
      m   = bm ? 16'h00FF : 16'hFFFF;
      top = bm ? 16'h0080 : 16'h8000;
      aa  = a & m;
      bb  = b & m;
      cy  = 1'b0;
      case (ai[4:1])
         4'h0, 4'h4: r = {1'b0, aa} + {1'b0, bb};
         4'h1: r = {1'b0, aa} + {1'b0, bb} + {16'h0, p[0]};
         4'h2, 4'h5: r = {1'b0, aa} + {1'b0, ~bb & m} + 17'd1;
         4'h3: r = {1'b0, aa} + {1'b0, ~bb & m} + {16'h0, p[0]};
         4'h6: r = {1'b0, aa ^ bb};
         4'h7, 4'h9: r = {1'b0, aa & bb};
         4'h8, 4'hB: r = {1'b0, aa | bb};
         4'hA: r = {1'b0, aa & ~bb};
         4'hC: r = {1'b0, (aa >> 1) | (((a & top) != 16'h0) ? top : 16'h0)};
         4'hD: r = {1'b0, (aa >> 1) | (p[0] ? top : 16'h0)};
         default: r = '0;
      endcase
      if (ai[4:1] <= 4'h5) cy = bm ? r[8] : r[16];
      else if (ai[4:1] >= 4'hC) cy = a[0];
      n   = (r[15:0] & top) != 16'h0;
      z   = (r[15:0] & m) == 16'h0;
      res = bm ? {a[15:8], r[7:0]} : r[15:0];
      return {p[15:3], n, z, cy, res};
   endfunction

   assign rf_rdata_a = regs[rf_raddr_a];
   assign rf_rdata_b = regs[rf_raddr_b];
   assign psw_i      = psw_m;
   assign {alu_psw_o, alu_result} = alu_f(alu_instr, alu_op1, alu_op2, alu_psw_i);
   assign outs_v = {ins_ready, rf_raddr_a, rf_raddr_b, rf_we, rf_waddr,
                    rf_wdata, psw_we, psw_wdata, alu_op1, alu_op2,
                    alu_instr, alu_opt, alu_e, alu_psw_i, done, illegal};

   always @(posedge clk) begin
      if (rf_we) regs[rf_waddr] <= rf_wdata;
      else if (tb_we) regs[tb_wa] <= tb_wd;
      if (psw_we) psw_m <= psw_wdata;
      else if (tb_pwe) psw_m <= tb_pd;
      if (rf_we || psw_we) wcount <= wcount + 1;
   end

   task automatic set_reg(input logic [2:0] a, input logic [15:0] d);
      @(negedge clk);
      tb_wa = a; tb_wd = d; tb_we = 1'b1;
      @(negedge clk);
      tb_we = 1'b0;
   endtask

   task automatic set_psw(input logic [15:0] d);
      @(negedge clk);
      tb_pd = d; tb_pwe = 1'b1;
      @(negedge clk);
      tb_pwe = 1'b0;
   endtask

   // Offer one word, then record cycles T+1..T+7 as bit masks (bit c = cycle T+c).
   task automatic issue(input logic [15:0] w, output obs_t o);
      int n;
      o = '0;
      n = 0;
      @(negedge clk);
      while (!ins_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if (ins_ready !== 1'b1) begin
         fails++;
         $display("FAIL issue_ready_timeout ins=%h got ins_ready=%b want 1", w, ins_ready);
      end
      ins = w;
      ins_valid = 1'b1;
      @(negedge clk);
      ins_valid = 1'b0;
      for (int c = 1; c < 8; c++) begin
         o.ae[c]  = alu_e;
         o.il[c]  = illegal;
         o.rdy[c] = ins_ready;
         o.rwe[c] = rf_we;
         o.pwe[c] = psw_we;
         o.dn[c]  = done;
         if (c == 1) begin
            o.ra = rf_raddr_a;
            o.rb = rf_raddr_b;
         end
         if (c == 2) o.instr = alu_instr;
         if (done) begin
            o.wa = rf_waddr;
            o.wd = rf_wdata;
            o.pd = psw_wdata;
         end
         if (int'(alu_e) + int'(illegal) + int'(rf_we | psw_we | done) > 1 ||
             ((rf_we || psw_we) && !done))
            o.excl++;
         if (c < 7) @(negedge clk);
      end
   endtask

   task automatic test_reset;
      repeat (2) @(negedge clk);
      tests++;
      if (outs_v !== '0) begin
         fails++;
         $display("FAIL reset_outputs got %h want 0", outs_v);
      end
      for (int i = 0; i < 8; i++) set_reg(3'(i), 16'($urandom));
      set_psw(16'h0000);
      rst = 1'b0;
      #1;
      tests++;
      if (ins_ready !== 1'b1) begin
         fails++;
         $display("FAIL reset_release_ready got %b want 1", ins_ready);
      end
   endtask

   task automatic test_add;
      obs_t o;
      set_reg(3'd1, 16'h0005);
      set_reg(3'd2, 16'h0003);
      set_psw(16'h0000);
      issue(16'h4011, o);
      tests++;
      if (o.ae !== 8'h04 || o.dn !== 8'h10 || o.rdy !== 8'hE0 || o.excl !== 0) begin
         fails++;
         $display("FAIL add_timing got ae=%h dn=%h rdy=%h excl=%0d want 04 10 e0 0",
                  o.ae, o.dn, o.rdy, o.excl);
      end
      tests++;
      if (o.rwe !== 8'h10 || o.pwe !== 8'h10 || o.wa !== 3'd1 || o.wd !== 16'h0008) begin
         fails++;
         $display("FAIL add_wb got rwe=%h pwe=%h wa=%0d wd=%h want 10 10 1 0008",
                  o.rwe, o.pwe, o.wa, o.wd);
      end
      tests++;
      if (o.pd[1] !== 1'b0 || regs[1] !== 16'h0008) begin
         fails++;
         $display("FAIL add_zflag_reg got z=%b r1=%h want 0 0008", o.pd[1], regs[1]);
      end
   endtask

   task automatic test_cmp;
      obs_t o;
      set_reg(3'd0, 16'h0001);
      issue(16'h45C8, o);
      tests++;
      if (o.rwe !== 8'h00 || o.pwe !== 8'h10 || o.pd[1] !== 1'b1) begin
         fails++;
         $display("FAIL cmp_wb got rwe=%h pwe=%h z=%b want 00 10 1", o.rwe, o.pwe, o.pd[1]);
      end
      tests++;
      if (regs[0] !== 16'h0001 || o.instr !== 6'h0B) begin
         fails++;
         $display("FAIL cmp_reg_instr got r0=%h instr=%h want 0001 0b", regs[0], o.instr);
      end
   endtask

   task automatic test_illegal;
      obs_t o;
      logic [15:0] words [2];
      words[0] = 16'h4E00;
      words[1] = 16'h1234;
      for (int i = 0; i < 2; i++) begin
         issue(words[i], o);
         tests++;
         if (o.il !== 8'h02 || o.ae !== 8'h00 || o.rwe !== 8'h00 ||
             o.pwe !== 8'h00 || o.dn !== 8'h00 || o.rdy !== 8'hFC) begin
            fails++;
            $display("FAIL illegal_%h got il=%h ae=%h rwe=%h pwe=%h dn=%h rdy=%h want 02 00 00 00 00 fc",
                     words[i], o.il, o.ae, o.rwe, o.pwe, o.dn, o.rdy);
         end
      end
   endtask

   task automatic test_back_to_back;
      logic [15:0] acc;
      set_reg(3'd1, 16'h0005);
      set_reg(3'd2, 16'h0003);
      acc = '0;
      @(negedge clk);
      ins = 16'h4011;
      ins_valid = 1'b1;
      for (int c = 0; c < 12; c++) begin
         if (ins_valid && ins_ready) acc[c] = 1'b1;
         if (c < 11) @(negedge clk);
      end
      ins_valid = 1'b0;
      repeat (8) @(negedge clk);
      tests++;
      if (acc !== 16'h0421) begin
         fails++;
         $display("FAIL b2b_accept_cycles got %h want 0421", acc);
      end
      tests++;
      if (regs[1] !== 16'h000E) begin
         fails++;
         $display("FAIL b2b_result got r1=%h want 000e", regs[1]);
      end
   endtask

   task automatic test_reset_mid;
      int w0;
      set_reg(3'd1, 16'h0005);
      set_reg(3'd2, 16'h0003);
      w0 = wcount;
      @(negedge clk);
      ins = 16'h4011;
      ins_valid = 1'b1;
      @(negedge clk);
      ins_valid = 1'b0;
      @(negedge clk);
      tests++;
      if (alu_e !== 1'b1) begin
         fails++;
         $display("FAIL rstmid_exec got alu_e=%b want 1", alu_e);
      end
      rst = 1'b1;
      #1;
      tests++;
      if (outs_v !== '0) begin
         fails++;
         $display("FAIL rstmid_outs_now got %h want 0", outs_v);
      end
      @(negedge clk);
      tests++;
      if (outs_v !== '0) begin
         fails++;
         $display("FAIL rstmid_outs_held got %h want 0", outs_v);
      end
      rst = 1'b0;
      #1;
      tests++;
      if (ins_ready !== 1'b1) begin
         fails++;
         $display("FAIL rstmid_ready got %b want 1", ins_ready);
      end
      repeat (6) @(negedge clk);
      tests++;
      if (wcount !== w0 || regs[1] !== 16'h0005) begin
         fails++;
         $display("FAIL rstmid_no_write got writes=%0d r1=%h want 0 0005", wcount - w0, regs[1]);
      end
   endtask

   task automatic test_shift;
      obs_t o;
      set_reg(3'd3, 16'h8002);
      issue(16'h4D03, o);
`ifdef ALU_ISSUE_SHIFT_EN
      tests++;
      if (o.rwe !== 8'h10 || o.wa !== 3'd3 || o.wd !== 16'hC001 || o.instr !== 6'h18) begin
         fails++;
         $display("FAIL shift_sra got rwe=%h wa=%0d wd=%h instr=%h want 10 3 c001 18",
                  o.rwe, o.wa, o.wd, o.instr);
      end
`else
      tests++;
      if (o.il !== 8'h02 || o.rwe !== 8'h00 || o.pwe !== 8'h00 || regs[3] !== 16'h8002) begin
         fails++;
         $display("FAIL shift_disabled got il=%h rwe=%h pwe=%h r3=%h want 02 00 00 8002",
                  o.il, o.rwe, o.pwe, regs[3]);
      end
`endif
   endtask

   task automatic test_random;
      obs_t o;
      logic [15:0] w, op2, er, ep;
      logic [3:0]  k;
      logic [2:0]  d, sc;
      logic [5:0]  ai;
      logic        leg, wr;
      for (int i = 0; i < 8; i++) set_reg(3'(i), 16'($urandom));
      set_psw(16'($urandom));
      for (int i = 0; i < 48; i++) begin
         w = 16'($urandom);
         if ($urandom_range(7, 0) != 0) w[15:12] = 4'h4;
         k   = w[11:8];
         sc  = w[5:3];
         d   = w[2:0];
         leg = (w[15:12] == 4'h4) && (k <= 4'hB);
         wr  = (k != 4'h5) && (k != 4'h9);
         ai  = {1'b0, k, w[6]};
`ifdef ALU_ISSUE_SHIFT_EN
         if (w[15:12] == 4'h4 && k == 4'hD && sc <= 3'd1) begin
            leg = 1'b1;
            ai  = {1'b0, (sc == 3'd0) ? 4'hC : 4'hD, w[6]};
         end
`endif
         op2 = w[7] ? ctab[sc] : regs[sc];
         {ep, er} = alu_f(ai, regs[d], op2, psw_m);
         issue(w, o);
         tests++;
         if (leg) begin
            if (o.ae !== 8'h04 || o.dn !== 8'h10 || o.pwe !== 8'h10 ||
                o.rwe !== (wr ? 8'h10 : 8'h00) || o.rdy !== 8'hE0 ||
                o.il !== 8'h00 || o.excl !== 0) begin
               fails++;
               $display("FAIL rand_timing ins=%h got ae=%h dn=%h pwe=%h rwe=%h rdy=%h il=%h excl=%0d want 04 10 10 %h e0 00 0",
                        w, o.ae, o.dn, o.pwe, o.rwe, o.rdy, o.il, o.excl, wr ? 8'h10 : 8'h00);
            end
            tests++;
            if (o.instr !== ai || o.ra !== d || o.rb !== sc || o.wa !== d ||
                o.pd !== ep || (wr && o.wd !== er)) begin
               fails++;
               $display("FAIL rand_data ins=%h got instr=%h ra=%0d rb=%0d wa=%0d wd=%h pd=%h want %h %0d %0d %0d %h %h",
                        w, o.instr, o.ra, o.rb, o.wa, o.wd, o.pd, ai, d, sc, d, er, ep);
            end
         end else begin
            if (o.il !== 8'h02 || o.ae !== 8'h00 || o.rwe !== 8'h00 ||
                o.pwe !== 8'h00 || o.dn !== 8'h00 || o.rdy !== 8'hFC) begin
               fails++;
               $display("FAIL rand_illegal ins=%h got il=%h ae=%h rwe=%h pwe=%h dn=%h rdy=%h want 02 00 00 00 00 fc",
                        w, o.il, o.ae, o.rwe, o.pwe, o.dn, o.rdy);
            end
         end
      end
   endtask

   initial begin
      ctab = '{16'h0000, 16'h0001, 16'h0002, 16'h0004,
               16'h0008, 16'h0010, 16'h0020, 16'hFFFF};
      test_reset();
      test_add();
      test_cmp();
      test_illegal();
      test_back_to_back();
      test_reset_mid();
      test_shift();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog_timeout got no finish want finish");
      $fatal(1, "watchdog");
   end

endmodule
